apple1_pia_term: RTL and testbench



---
 rtl/apple1_pia_term_if.sv | 42 ++++
 rtl/apple1_pia_term.sv | 192 +++++++++++++++++++
 tb/tb_apple1_pia_term.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/apple1_pia_term_if.sv
// ---------------------------------------------------------------------------
// apple1_pia_term_if
// Bus bundle for the Apple-1 terminal port. It carries both the CPU register
// bus and the two UART byte streams, so the PIA needs only clk/reset besides
// this interface.
//
// Signals:
//   cs, addr[1:0], rd_en, wr_en, din[7:0]  CPU -> PIA register access
//   dout[7:0]                              PIA -> CPU read data (registered)
//   rx_data[7:0], rx_valid                 UART receiver -> PIA keystrokes
//   rx_ready                               PIA -> UART, keyboard FIFO not full
//   tx_data[7:0], tx_valid                 PIA -> UART transmitter display byte
//   tx_ready                               UART transmitter -> PIA accept
//
// Modports:
//   master : the CPU/UART side (drives strobes, write data, rx stream, tx_ready)
//   slave  : the PIA itself
// ---------------------------------------------------------------------------
interface apple1_pia_term_if;
  logic       cs;
  logic [1:0] addr;
  logic       rd_en;
  logic       wr_en;
  logic [7:0] din;
  logic [7:0] dout;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output cs, addr, rd_en, wr_en, din, rx_data, rx_valid, tx_ready,
    input  dout, rx_ready, tx_data, tx_valid
  );

  modport slave (
    input  cs, addr, rd_en, wr_en, din, rx_data, rx_valid, tx_ready,
    output dout, rx_ready, tx_data, tx_valid
  );
endinterface

// File: rtl/apple1_pia_term.sv
// ---------------------------------------------------------------------------
// apple1_pia_term
// Apple-1 terminal port: a 6821 PIA subset mapped at $D010-$D013.
//   addr 0 KBD   (R)   {1, key[6:0]}; reading pops the keyboard FIFO
//   addr 1 KBDCR (R/W) read {key_available, kbdcr[6:0]}
//   addr 2 DSP   (R/W) write queues a display byte; read {busy, tx_hold[6:0]}
//   addr 3 DSPCR (R/W) read {0, dsp_ovf, dspcr[5:0]}; din[6]=1 clears dsp_ovf
//
// Ports:
//   clk    system clock shared with the CPU core
//   reset  synchronous, active-high reset
//   bus    apple1_pia_term_if.slave (CPU register bus + UART rx/tx streams)
//
// Parameter:
//   RX_DEPTH  keyboard FIFO depth, power of two in 2..16
//
// Build option:
//   PIA_UPCASE_EN  when defined, keystrokes 'a'-'z' are stored upper-case and
//                  LF is stored as CR so WozMon's parser accepts them.
// ---------------------------------------------------------------------------
module apple1_pia_term #(
  parameter int RX_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  apple1_pia_term_if.slave       bus
);

  localparam int AW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;

  typedef enum logic [0:0] {
    TX_IDLE = 1'b0,
    TX_BUSY = 1'b1
  } tx_state_t;

  // Key translation applied on FIFO push; bit 7 is already stripped.
  function automatic logic [6:0] store_key(input logic [6:0] key);
`ifdef PIA_UPCASE_EN
    logic [6:0] mapped;
    if ((key >= 7'h61) && (key <= 7'h7A)) begin
      mapped = key - 7'h20;
    end else if (key == 7'h0A) begin
      mapped = 7'h0D;
    end else begin
      mapped = key;
    end
    return mapped;
`else
    return key;
`endif
  endfunction

  logic [6:0]  fifo_mem_r [RX_DEPTH];
  logic [AW:0] wptr_r;
  logic [AW:0] rptr_r;
  logic [6:0]  last_key_r;
  logic [6:0]  kbdcr_r;
  logic [5:0]  dspcr_r;
  logic        dsp_ovf_r;
  logic [6:0]  tx_hold_r;
  tx_state_t   tx_state_r;
  logic [7:0]  dout_r;

  logic        rd_s;
  logic        wr_s;
  logic        empty_s;
  logic        full_s;
  logic        pop_s;
  logic        push_s;
  logic        dsp_wr_s;
  logic        tx_busy_s;
  logic [6:0]  head_s;
  logic [7:0]  rd_data_s;
  logic        unused_bits_s;

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Bit 7 of write data and received bytes is architecturally ignored.
  assign unused_bits_s = ^{bus.din[7], bus.rx_data[7]};

  // Access decode and FIFO status derived from the registered pointers.
  always_comb begin
    rd_s      = bus.cs & bus.rd_en;
    wr_s      = bus.cs & bus.wr_en;
    tx_busy_s = (tx_state_r == TX_BUSY);
    empty_s   = (wptr_r == rptr_r);
    full_s    = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
    head_s    = fifo_mem_r[rptr_r[AW-1:0]];
    pop_s     = rd_s & (bus.addr == 2'd0) & ~empty_s;
    // A pop frees the head slot on the same edge, so a push while full still
    // lands (into the slot being vacated) and the count stays unchanged.
    push_s    = bus.rx_valid & (~full_s | pop_s);
    dsp_wr_s  = wr_s & (bus.addr == 2'd2);
  end

  // Read data mux; uses pre-edge state so a read-with-write returns old contents.
  always_comb begin
    rd_data_s = 8'h00;
    case (bus.addr)
      2'd0: begin
        if (empty_s) begin
          rd_data_s = {1'b1, last_key_r};
        end else begin
          rd_data_s = {1'b1, head_s};
        end
      end
      2'd1:    rd_data_s = {~empty_s, kbdcr_r};
      2'd2:    rd_data_s = {tx_busy_s, tx_hold_r};
      2'd3:    rd_data_s = {1'b0, dsp_ovf_r, dspcr_r};
      default: rd_data_s = 8'h00;
    endcase
  end

  // Keyboard FIFO storage; contents need no reset since the pointers gate use.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wptr_r[AW-1:0]] <= store_key(bus.rx_data[6:0]);
    end
  end

  // Keyboard FIFO pointers and the last key handed to the CPU.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_r     <= '0;
      rptr_r     <= '0;
      last_key_r <= 7'h00;
    end else begin
      if (push_s) begin
        wptr_r <= wptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rptr_r     <= rptr_r + PTR_ONE;
        last_key_r <= head_s;
      end
    end
  end

  // Control registers, display overflow flag and registered read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      kbdcr_r   <= 7'h00;
      dspcr_r   <= 6'h00;
      dsp_ovf_r <= 1'b0;
      dout_r    <= 8'h00;
    end else begin
      if (wr_s && (bus.addr == 2'd1)) begin
        kbdcr_r <= bus.din[6:0];
      end
      if (wr_s && (bus.addr == 2'd3)) begin
        dspcr_r <= bus.din[5:0];
      end
      // A dropped display write outranks a same-cycle clear so it is never lost.
      if (dsp_wr_s && tx_busy_s) begin
        dsp_ovf_r <= 1'b1;
      end else if (wr_s && (bus.addr == 2'd3) && bus.din[6]) begin
        dsp_ovf_r <= 1'b0;
      end
      if (rd_s) begin
        dout_r <= rd_data_s;
      end
    end
  end

  // Display transmit FSM: one byte in flight, released by the UART handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_r <= TX_IDLE;
      tx_hold_r  <= 7'h00;
    end else begin
      case (tx_state_r)
        TX_IDLE: begin
          if (dsp_wr_s) begin
            tx_hold_r  <= bus.din[6:0];
            tx_state_r <= TX_BUSY;
          end
        end
        TX_BUSY: begin
          if (bus.tx_ready) begin
            tx_state_r <= TX_IDLE;
          end
        end
        default: tx_state_r <= TX_IDLE;
      endcase
    end
  end

  assign bus.dout     = dout_r;
  assign bus.rx_ready = ~full_s;
  assign bus.tx_valid = tx_busy_s;
  assign bus.tx_data  = {1'b0, tx_hold_r};

endmodule

// File: tb/tb_apple1_pia_term.sv
// ---------------------------------------------------------------------------
// tb_apple1_pia_term
// Directed bench for apple1_pia_term (RX_DEPTH=4). Stimulus pushes expected
// read data and expected display bytes into queues; a monitor on the falling
// edge pops and compares whenever a read result or a tx handshake appears.
// Inputs change 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_apple1_pia_term;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  apple1_pia_term_if bus();

  apple1_pia_term #(.RX_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_rd_q [$];
  string      exp_nm_q [$];
  logic [7:0] exp_tx_q [$];
  logic       rd_pend = 1'b0;

`ifdef PIA_UPCASE_EN
  localparam logic [7:0] UP_E  = 8'hC5;
  localparam logic [7:0] UP_LF = 8'h8D;
`else
  localparam logic [7:0] UP_E  = 8'hE5;
  localparam logic [7:0] UP_LF = 8'h8A;
`endif

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: read results appear one edge after the strobe; tx handshakes
  // are seen before the edge on which they complete.
  always @(negedge clk) begin
    logic [7:0] e;
    string      n;
    if (rd_pend) begin
      if (exp_rd_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_read: got %0h expected none", bus.dout);
      end else begin
        e = exp_rd_q.pop_front();
        n = exp_nm_q.pop_front();
        check(n, {24'h0, bus.dout}, {24'h0, e});
      end
    end
    rd_pend <= ~reset & bus.cs & bus.rd_en;
    if (!reset && bus.tx_valid && bus.tx_ready) begin
      if (exp_tx_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_tx: got %0h expected none", bus.tx_data);
      end else begin
        e = exp_tx_q.pop_front();
        check("tx_byte", {24'h0, bus.tx_data}, {24'h0, e});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] exp, input string nm);
    exp_rd_q.push_back(exp);
    exp_nm_q.push_back(nm);
    bus.cs = 1'b1; bus.addr = a; bus.rd_en = 1'b1;
    tick();
    bus.cs = 1'b0; bus.rd_en = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    bus.cs = 1'b1; bus.addr = a; bus.wr_en = 1'b1; bus.din = d;
    tick();
    bus.cs = 1'b0; bus.wr_en = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    bus.rx_valid = 1'b1; bus.rx_data = b;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] wrap_v [4];
    wrap_v[0] = 8'h11; wrap_v[1] = 8'h22; wrap_v[2] = 8'h33; wrap_v[3] = 8'h44;
    bus.cs = 1'b0; bus.addr = 2'd0; bus.rd_en = 1'b0; bus.wr_en = 1'b0;
    bus.din = 8'h00; bus.rx_data = 8'h00; bus.rx_valid = 1'b0; bus.tx_ready = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    check("reset_dout", {24'h0, bus.dout}, 32'h0);
    check("reset_rx_ready", {31'h0, bus.rx_ready}, 32'h1);
    check("reset_tx_valid", {31'h0, bus.tx_valid}, 32'h0);
    check("reset_tx_data", {24'h0, bus.tx_data}, 32'h0);
    reset = 1'b0;
    rd(2'd1, 8'h00, "kbdcr_reset");
    rd(2'd2, 8'h00, "dsp_reset");
    rd(2'd0, 8'h80, "kbd_reset");

    // "E000R<CR>" through a 4-deep FIFO.
    push(8'h45); push(8'h30); push(8'h30); push(8'h30);
    check("rx_full_after_4", {31'h0, bus.rx_ready}, 32'h0);
    rd(2'd1, 8'h80, "kbdcr_nonempty");
    rd(2'd0, 8'hC5, "kbd_E");
    rd(2'd0, 8'hB0, "kbd_0a");
    push(8'h52); push(8'h0D);
    rd(2'd0, 8'hB0, "kbd_0b");
    rd(2'd0, 8'hB0, "kbd_0c");
    rd(2'd0, 8'hD2, "kbd_R");
    rd(2'd0, 8'h8D, "kbd_CR");
    rd(2'd1, 8'h00, "kbdcr_empty");
    rd(2'd0, 8'h8D, "kbd_empty_lastkey");

    // Fill with rx_valid held, fifth byte waits, then pop+push while full.
    for (int i = 0; i < 4; i++) begin
      bus.rx_valid = 1'b1; bus.rx_data = wrap_v[i];
      tick();
    end
    bus.rx_data = 8'h55;
    tick();
    tick();
    check("rx_ready_full_held", {31'h0, bus.rx_ready}, 32'h0);
    exp_rd_q.push_back(8'h91);
    exp_nm_q.push_back("kbd_pop_push_full");
    bus.cs = 1'b1; bus.addr = 2'd0; bus.rd_en = 1'b1;
    tick();
    bus.cs = 1'b0; bus.rd_en = 1'b0; bus.rx_valid = 1'b0;
    check("full_after_pop_push", {31'h0, bus.rx_ready}, 32'h0);
    rd(2'd0, 8'hA2, "kbd_wrap_22");
    rd(2'd0, 8'hB3, "kbd_wrap_33");
    rd(2'd0, 8'hC4, "kbd_wrap_44");
    rd(2'd0, 8'hD5, "kbd_wrap_55");
    check("rx_ready_drained", {31'h0, bus.rx_ready}, 32'h1);
    rd(2'd1, 8'h00, "kbdcr_drained");

    // Key translation option.
    push(8'h65); push(8'h0A);
    rd(2'd0, UP_E, "kbd_lower_e");
    rd(2'd0, UP_LF, "kbd_lf");

    // KBDCR write, chip-select gating, read-with-write.
    wr(2'd1, 8'hFF);
    rd(2'd1, 8'h7F, "kbdcr_write");
    bus.addr = 2'd1; bus.wr_en = 1'b1; bus.din = 8'h00;
    tick();
    bus.wr_en = 1'b0;
    rd(2'd1, 8'h7F, "kbdcr_cs_low_wr");
    bus.addr = 2'd0; bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    check("dout_hold_cs_low", {24'h0, bus.dout}, 32'h7F);
    exp_rd_q.push_back(8'h7F);
    exp_nm_q.push_back("kbdcr_rd_wr_old");
    bus.cs = 1'b1; bus.addr = 2'd1; bus.rd_en = 1'b1; bus.wr_en = 1'b1; bus.din = 8'h05;
    tick();
    bus.cs = 1'b0; bus.rd_en = 1'b0; bus.wr_en = 1'b0;
    rd(2'd1, 8'h05, "kbdcr_rd_wr_new");

    // Display path: busy, dropped write, handshake, overflow clear.
    wr(2'd2, 8'hC1);
    check("tx_valid_after_wr", {31'h0, bus.tx_valid}, 32'h1);
    check("tx_data_after_wr", {24'h0, bus.tx_data}, 32'h41);
    rd(2'd2, 8'hC1, "dsp_busy");
    wr(2'd2, 8'hC2);
    rd(2'd3, 8'h40, "dspcr_ovf");
    check("tx_data_kept", {24'h0, bus.tx_data}, 32'h41);
    exp_tx_q.push_back(8'h41);
    bus.tx_ready = 1'b1;
    tick();
    bus.tx_ready = 1'b0;
    check("tx_valid_after_hs", {31'h0, bus.tx_valid}, 32'h0);
    rd(2'd2, 8'h41, "dsp_idle");
    wr(2'd3, 8'h40);
    rd(2'd3, 8'h00, "dspcr_ovf_clear");
    wr(2'd3, 8'h15);
    rd(2'd3, 8'h15, "dspcr_write");

    // tx_ready already high: exactly one valid cycle.
    bus.tx_ready = 1'b1;
    exp_tx_q.push_back(8'h57);
    wr(2'd2, 8'hD7);
    check("tx_valid_one_cycle", {31'h0, bus.tx_valid}, 32'h1);
    tick();
    check("tx_valid_dropped", {31'h0, bus.tx_valid}, 32'h0);
    bus.tx_ready = 1'b0;

    // Reset with a pending display byte and queued keys.
    wr(2'd2, 8'hCA);
    check("pending_before_reset", {31'h0, bus.tx_valid}, 32'h1);
    push(8'h31); push(8'h32);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_tx_valid", {31'h0, bus.tx_valid}, 32'h0);
    check("rst_tx_data", {24'h0, bus.tx_data}, 32'h0);
    check("rst_rx_ready", {31'h0, bus.rx_ready}, 32'h1);
    check("rst_dout", {24'h0, bus.dout}, 32'h0);
    rd(2'd1, 8'h00, "kbdcr_after_reset");
    rd(2'd3, 8'h00, "dspcr_after_reset");
    rd(2'd0, 8'h80, "kbd_after_reset");
    bus.tx_ready = 1'b1;
    tick(); tick(); tick();
    check("no_tx_after_reset", {31'h0, bus.tx_valid}, 32'h0);
    bus.tx_ready = 1'b0;

    tick(); tick();
    check("rd_queue_drained", exp_rd_q.size(), 32'h0);
    check("tx_queue_drained", exp_tx_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
